data_memory_arbiter: RTL
========================

Name: data_memory_arbiter

Overview:
Shares the single-port synchronous data memory between processor stage 2 and a host requester (UART loader / debug monitor).
- The processor owns the port while it runs.
- While the processor is parked by a wait instruction (waiting_global), the host may read and write the memory one word per cycle through a req/ack handshake.
- Sits between processor stage 2's memory interface and the data RAM instance.

Parameters:
ADDR_SIZE, 18, width of all memory addresses
WORD_SIZE, 18, width of memory data words
COUNT_SIZE, 16, width of host access counter

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cpu_addr  input  ADDR_SIZE  stage 2 memory_addr
cpu_write_enable  input  1  stage 2 memory_write_enable
cpu_data_in  input  WORD_SIZE  stage 2 memory_in
cpu_waiting  input  1  stage 2 waiting_global
host_req  input  1  host access request, held until acked
host_write  input  1  1 = write, 0 = read
host_addr  input  ADDR_SIZE  host address
host_data  input  WORD_SIZE  host write data
host_ack  output  1  request accepted this cycle
host_rdata  output  WORD_SIZE  read data
host_rdata_valid  output  1  host_rdata valid this cycle
mem_addr  output  ADDR_SIZE  to RAM
mem_write_enable  output  1  to RAM
mem_data_in  output  WORD_SIZE  to RAM write port
mem_data_out  input  WORD_SIZE  RAM read data, 1-cycle latency
host_granted  output  1  state == ST_HOST
host_access_count  output  COUNT_SIZE  accepted host accesses since reset
cpu_write_dropped  output  1  sticky error flag

Behaviour:
Interface and reset:
- Single clock domain: clock. reset is synchronous and active-high.
- On reset: state = ST_CPU, host_rdata_valid = 0, host_access_count = 0, cpu_write_dropped = 0.
- Combinational outputs reset to their ST_CPU values: host_ack = 0, host_granted = 0, mem_* = cpu_*.

States:
- ST_CPU:
  - mem_addr, mem_write_enable and mem_data_in pass through from cpu_* combinationally, with zero latency. This is mandatory because stage 2 drives its address in the same cycle it consumes data.
  - host_ack = 0.
  - If cpu_waiting = 1, go to ST_GUARD.
- ST_GUARD (one cycle):
  - mem_write_enable = 0, mem_addr = cpu_addr, host_ack = 0.
  - Next state is ST_HOST if cpu_waiting = 1, else ST_CPU.
- ST_HOST:
  - If host_req = 1:
    - host_ack = 1 in the same cycle.
    - mem_addr = host_addr, mem_write_enable = host_write, mem_data_in = host_data.
    - host_access_count increments and wraps at 2^COUNT_SIZE.
  - If host_req = 0: mem_write_enable = 0.
  - If cpu_waiting falls to 0 (processor reset), go to ST_HANDBACK. Any request in that same cycle is still accepted.
- ST_HANDBACK (one cycle):
  - mem_write_enable = 0, host_ack = 0.
  - The pending read response is still delivered.
  - Next state is ST_CPU.

Read return:
- host_rdata_valid is registered and equals (host_ack && !host_write) from the previous cycle.
- host_rdata = mem_data_out (RAM registered output), valid only when host_rdata_valid = 1.
- Back-to-back host reads return one word per cycle.

Dropped-write rule:
- cpu_write_enable = 1 in any state other than ST_CPU is ignored and sets cpu_write_dropped.
- The flag clears only on reset.

Boundaries:
- host_req asserted in ST_CPU or ST_GUARD: not acked, stays pending. It is not an error.
- Reset asserted mid-host-access: the access completes in RAM if acked that cycle; the valid pulse is suppressed and state returns to ST_CPU.
- Addresses pass through unchanged; there is no range check.

Decomposition:
- Package processor_pkg (shared):
  - state enum arbiter_state_t {ST_CPU, ST_GUARD, ST_HOST, ST_HANDBACK}
  - constant ARB_STATE_BITS = 2
- One natural sub-module: memory_port_mux, the combinational 3-way select (cpu / host / idle) of addr/we/data keyed by state and host_ack. The FSM, counter and valid register stay in the top module.

Test Plan:
- Reset, then cpu_addr = 0x00123, cpu_write_enable = 1, cpu_data_in = 0x2AAAA in ST_CPU -> same-cycle mem_addr = 0x00123, mem_write_enable = 1, mem_data_in = 0x2AAAA; host_req = 1 held -> host_ack stays 0.
- cpu_waiting rises at cycle N with host_req held (write, addr 0x00010, data 0x15555) -> ST_GUARD at N+1, host_ack = 1 at N+2, mem_write_enable = 1, host_access_count = 1.
- In ST_HOST, host reads at addrs 0x10, 0x11, 0x12 on consecutive cycles, RAM preloaded 0x15555/0x00001/0x3FFFF -> host_rdata_valid high for 3 cycles starting 1 cycle after first ack, data in order.
- In ST_HOST, cpu_waiting falls during a host read -> read acked, ST_HANDBACK next cycle with valid = 1 and correct data; ST_CPU the cycle after; mem_* follows cpu_*.
- In ST_HOST, pulse cpu_write_enable = 1 -> mem_write_enable unaffected (0 with no host_req); cpu_write_dropped = 1 and stays set until reset.
- Set host_access_count = 0xFFFF via 65535 acks plus 1 -> wraps to 0; assert reset mid-burst -> valid suppressed next cycle, all counters/flags 0, state ST_CPU.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared processor types: data-memory arbiter states and memory port select.
package processor_pkg;

    localparam int unsigned ARB_STATE_BITS = 2;
    localparam int unsigned PORT_SEL_BITS  = 2;

    typedef enum logic [ARB_STATE_BITS-1:0] {
        ST_CPU      = 2'd0,
        ST_GUARD    = 2'd1,
        ST_HOST     = 2'd2,
        ST_HANDBACK = 2'd3
    } arbiter_state_t;

    typedef enum logic [PORT_SEL_BITS-1:0] {
        PORT_CPU  = 2'd0,
        PORT_HOST = 2'd1,
        PORT_IDLE = 2'd2
    } port_sel_t;

    // Owner of the RAM port: cpu while running, host only on an accepted request.
    function automatic port_sel_t port_select(input arbiter_state_t state,
                                              input logic           host_ack);
        port_sel_t sel;
        sel = PORT_IDLE;
        if (state == ST_CPU) begin
            sel = PORT_CPU;
        end else if ((state == ST_HOST) && host_ack) begin
            sel = PORT_HOST;
        end
        return sel;
    endfunction

endpackage

// File: rtl/memory_port_mux.sv
// Combinational cpu/host/idle select of the data RAM address, write enable and write data.
module memory_port_mux
    import processor_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 18,
    parameter int unsigned WORD_SIZE = 18
) (
    input  arbiter_state_t       state,
    input  logic                 host_ack,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic                 cpu_write_enable,
    input  logic [WORD_SIZE-1:0] cpu_data_in,
    input  logic                 host_write,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [WORD_SIZE-1:0] host_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_write_enable,
    output logic [WORD_SIZE-1:0] mem_data_in
);

    port_sel_t sel;

    always_comb begin
        sel              = port_select(state, host_ack);
        mem_addr         = cpu_addr;
        mem_write_enable = 1'b0;
        mem_data_in      = cpu_data_in;
        unique case (sel)
            PORT_CPU: begin
                mem_write_enable = cpu_write_enable;
            end
            PORT_HOST: begin
                mem_addr         = host_addr;
                mem_write_enable = host_write;
                mem_data_in      = host_data;
            end
            // Idle keeps the cpu address on the port so nothing toggles needlessly.
            default: begin
                mem_write_enable = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port data RAM between processor stage 2 and a host
// requester that may access memory only while the processor is parked.
module data_memory_arbiter
    import processor_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 18,
    parameter int unsigned WORD_SIZE  = 18,
    parameter int unsigned COUNT_SIZE = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_SIZE-1:0]  cpu_addr,
    input  logic                  cpu_write_enable,
    input  logic [WORD_SIZE-1:0]  cpu_data_in,
    input  logic                  cpu_waiting,
    input  logic                  host_req,
    input  logic                  host_write,
    input  logic [ADDR_SIZE-1:0]  host_addr,
    input  logic [WORD_SIZE-1:0]  host_data,
    output logic                  host_ack,
    output logic [WORD_SIZE-1:0]  host_rdata,
    output logic                  host_rdata_valid,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic                  mem_write_enable,
    output logic [WORD_SIZE-1:0]  mem_data_in,
    input  logic [WORD_SIZE-1:0]  mem_data_out,
    output logic                  host_granted,
    output logic [COUNT_SIZE-1:0] host_access_count,
    output logic                  cpu_write_dropped
);

    arbiter_state_t state;
    arbiter_state_t next_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_CPU;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the same-cycle grant/ack, which the RAM port needs with zero latency.
    always_comb begin
        next_state   = state;
        host_ack     = 1'b0;
        host_granted = 1'b0;
        unique case (state)
            ST_CPU: begin
                if (cpu_waiting) begin
                    next_state = ST_GUARD;
                end
            end
            ST_GUARD: begin
                next_state = cpu_waiting ? ST_HOST : ST_CPU;
            end
            ST_HOST: begin
                host_granted = 1'b1;
                host_ack     = host_req;
                if (!cpu_waiting) begin
                    next_state = ST_HANDBACK;
                end
            end
            ST_HANDBACK: begin
                next_state = ST_CPU;
            end
            default: begin
                next_state = ST_CPU;
            end
        endcase
    end

    memory_port_mux #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_port_mux (
        .state            (state),
        .host_ack         (host_ack),
        .cpu_addr         (cpu_addr),
        .cpu_write_enable (cpu_write_enable),
        .cpu_data_in      (cpu_data_in),
        .host_write       (host_write),
        .host_addr        (host_addr),
        .host_data        (host_data),
        .mem_addr         (mem_addr),
        .mem_write_enable (mem_write_enable),
        .mem_data_in      (mem_data_in)
    );

    // RAM output is already registered, so read data is forwarded as-is.
    assign host_rdata = mem_data_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            host_rdata_valid <= 1'b0;
        end else begin
            host_rdata_valid <= host_ack && !host_write;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            host_access_count <= '0;
        end else if (host_ack) begin
            host_access_count <= host_access_count + COUNT_SIZE'(1);
        end
    end

    // A cpu write outside ST_CPU never reaches the RAM; remember that it happened.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_write_dropped <= 1'b0;
        end else if (cpu_write_enable && (state != ST_CPU)) begin
            cpu_write_dropped <= 1'b1;
        end
    end

endmodule
